// File: rtl/elevator_controller.sv
// elevator_controller: sweep-policy elevator car controller with travel and door timers
module elevator_controller #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3,
  parameter int MOVE_TICKS = 50,
  parameter int DOOR_TICKS = 150,
  parameter int CNT_W      = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MOVE_UP   = 2'd1;
  localparam logic [1:0] MOVE_DOWN = 2'd2;
  localparam logic [1:0] DOOR_OPEN = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [CNT_W-1:0]      timer, timer_nxt;
  logic [FLOOR_W-1:0]    floor_nxt;
  logic                  dir_nxt, above, below, here, here_call;
  logic [NUM_FLOORS-1:0] onehot, clr;

  assign onehot    = NUM_FLOORS'(1) << current_floor;
  assign here_call = |(call_req & onehot);
  assign here      = |(pending & onehot) | here_call;
  assign clr       = (state_nxt == DOOR_OPEN || state == DOOR_OPEN) ? onehot : '0;
  assign moving    = state == MOVE_UP || state == MOVE_DOWN;
  assign door_open = state == DOOR_OPEN;

  // Outstanding requests strictly above / below the car
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above = above | (pending[i] && FLOOR_W'(i) > current_floor);
      below = below | (pending[i] && FLOOR_W'(i) < current_floor);
    end
  end

  // Next state: an idle decision cycle between floors keeps the sweep direction while work lies ahead
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    floor_nxt = current_floor;
    dir_nxt   = dir_up;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (here) state_nxt = DOOR_OPEN;
        else if (above && (dir_up || !below)) begin
          state_nxt = MOVE_UP;
          dir_nxt   = 1'b1;
        end else if (below) begin
          state_nxt = MOVE_DOWN;
          dir_nxt   = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        timer_nxt = timer + 1'b1;
        if (timer == CNT_W'(MOVE_TICKS - 1)) begin
          timer_nxt = '0;
          state_nxt = IDLE;
          floor_nxt = state == MOVE_UP ? current_floor + 1'b1 : current_floor - 1'b1;
        end
      end
      default: begin
        timer_nxt = timer + 1'b1;
        if (here_call) timer_nxt = '0;
        else if (timer == CNT_W'(DOOR_TICKS - 1)) begin
          timer_nxt = '0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // State, timer, position and request registers; clearing the served floor beats a new call
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      current_floor <= floor_nxt;
      dir_up        <= dir_nxt;
      pending       <= (pending | call_req) & ~clr;
    end
  end
endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed scenarios checked against a countdown-based car model
module tb_elevator_controller;
  localparam int MT = 4;
  localparam int DT = 6;
  localparam int M_IDLE = 10, M_UP = 20, M_DOWN = 30, M_DOOR = 40;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] call_req = '0;
  logic [2:0] current_floor;
  logic       dir_up, moving, door_open;
  logic [7:0] pending;

  int total = 0;
  int bad = 0;
  bit started = 0;

  int         m_floor, m_mode, m_left;
  bit         m_up;
  logic [7:0] m_pend;

  elevator_controller #(
    .NUM_FLOORS(8), .FLOOR_W(3), .MOVE_TICKS(MT), .DOOR_TICKS(DT), .CNT_W(8)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .call_req(call_req), .current_floor(current_floor),
    .dir_up(dir_up), .moving(moving), .door_open(door_open), .pending(pending)
  );

  initial forever #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input logic [7:0] c);
    call_req = c;
    tick();
    call_req = '0;
  endtask

  // Model: car phases with remaining-cycle countdowns
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_floor <= 0;
      m_up    <= 1'b1;
      m_mode  <= M_IDLE;
      m_left  <= 0;
      m_pend  <= '0;
    end else begin : step
      int f, mode, left;
      bit up, ab, be;
      f = m_floor; mode = m_mode; left = m_left; up = m_up;
      ab = 0; be = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i] && i > f) ab = 1;
        if (m_pend[i] && i < f) be = 1;
      end
      if (mode == M_IDLE) begin
        if (m_pend[f] || call_req[f]) begin mode = M_DOOR; left = DT; end
        else if (up && ab) begin mode = M_UP; left = MT; end
        else if (up && be) begin mode = M_DOWN; left = MT; up = 0; end
        else if (!up && be) begin mode = M_DOWN; left = MT; end
        else if (!up && ab) begin mode = M_UP; left = MT; up = 1; end
      end else if (mode == M_DOOR) begin
        if (call_req[f]) left = DT;
        else begin
          left = left - 1;
          if (left == 0) mode = M_IDLE;
        end
      end else begin
        left = left - 1;
        if (left == 0) begin
          f = mode == M_UP ? f + 1 : f - 1;
          mode = M_IDLE;
        end
      end
      m_pend  <= (m_pend | call_req) & ~((m_mode == M_DOOR || mode == M_DOOR) ? (8'd1 << m_floor) : 8'd0);
      m_floor <= f;
      m_mode  <= mode;
      m_left  <= left;
      m_up    <= up;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk_in) begin
    if (started) begin
      check("floor", 32'(current_floor), 32'(m_floor));
      check("dir_up", 32'(dir_up), 32'(m_up));
      check("moving", 32'(moving), 32'(m_mode == M_UP || m_mode == M_DOWN));
      check("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
      check("pending", 32'(pending), 32'(m_pend));
      check("exclusive", 32'(moving & door_open), 32'd0);
    end
  end

  initial begin
    repeat (3) tick();
    started = 1;
    check("rst_floor", 32'(current_floor), 0);
    check("rst_dir", 32'(dir_up), 1);
    check("rst_moving", 32'(moving), 0);
    check("rst_door", 32'(door_open), 0);
    check("rst_pending", 32'(pending), 0);
    rst_n = 1'b1;
    tick();

    // 1: single call to floor 3
    pulse(8'h08);
    check("t1_pend_k", 32'(pending), 32'h08);
    check("t1_idle_k", 32'(moving), 0);
    tick();
    check("t1_move_k1", 32'(moving), 1);
    repeat (4) tick();
    check("t1_floor1_k5", 32'(current_floor), 1);
    repeat (5) tick();
    check("t1_floor2_k10", 32'(current_floor), 2);
    repeat (5) tick();
    check("t1_floor3_k15", 32'(current_floor), 3);
    tick();
    check("t1_door_k16", 32'(door_open), 1);
    check("t1_clr_k16", 32'(pending), 0);
    repeat (5) tick();
    check("t1_door_k21", 32'(door_open), 1);
    tick();
    check("t1_idle_k22", 32'(door_open), 0);

    // 2: call at the floor the car idles on
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse(8'h01);
    check("t2_door", 32'(door_open), 1);
    check("t2_pend", 32'(pending), 0);
    repeat (5) begin
      check("t2_nomove", 32'(moving), 0);
      tick();
    end
    check("t2_door_last", 32'(door_open), 1);
    tick();
    check("t2_closed", 32'(door_open), 0);

    // 3: sweep up to 5, then reverse for 1
    pulse(8'h20);
    for (int i = 0; i < 100 && !(current_floor == 3'd2 && moving); i++) tick();
    check("t3_at2_moving", 32'({current_floor, moving}), 32'({3'd2, 1'b1}));
    pulse(8'h02);
    for (int i = 0; i < 100 && !door_open; i++) tick();
    check("t3_serve5", 32'({current_floor, dir_up, door_open}), 32'({3'd5, 1'b1, 1'b1}));
    for (int i = 0; i < 100 && door_open; i++) tick();
    for (int i = 0; i < 100 && !door_open; i++) tick();
    check("t3_serve1", 32'({current_floor, dir_up, door_open}), 32'({3'd1, 1'b0, 1'b1}));
    for (int i = 0; i < 100 && door_open; i++) tick();

    // 4: repeated call at floor 4 extends the dwell
    pulse(8'h10);
    for (int i = 0; i < 100 && !door_open; i++) tick();
    check("t4_at4", 32'({current_floor, dir_up, door_open}), 32'({3'd4, 1'b1, 1'b1}));
    repeat (4) tick();
    pulse(8'h10);
    check("t4_pend4", 32'(pending), 0);
    repeat (5) tick();
    check("t4_still_open", 32'(door_open), 1);
    tick();
    check("t4_closed", 32'(door_open), 0);

    // 5: reset in the middle of travel 6 -> 5
    pulse(8'h40);
    for (int i = 0; i < 100 && !door_open; i++) tick();
    for (int i = 0; i < 100 && door_open; i++) tick();
    pulse(8'h01);
    for (int i = 0; i < 100 && !(moving && !dir_up); i++) tick();
    tick();
    pulse(8'h80);
    check("t5_mid_move", 32'({current_floor, moving, pending}), 32'({3'd6, 1'b1, 8'h81}));
    rst_n = 1'b0;
    #1;
    check("t5_async", 32'({current_floor, dir_up, moving, door_open, pending}),
          32'({3'd0, 1'b1, 1'b0, 1'b0, 8'h00}));
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t5_quiet", 32'({current_floor, moving, door_open, pending}), 32'({3'd0, 1'b0, 1'b0, 8'h00}));

    // 6: calls 0 and 7 together while parked at floor 7
    pulse(8'h80);
    for (int i = 0; i < 100 && !door_open; i++) tick();
    check("t6_at7", 32'(current_floor), 7);
    for (int i = 0; i < 100 && door_open; i++) tick();
    pulse(8'h81);
    check("t6_door7_first", 32'({door_open, pending}), 32'({1'b1, 8'h01}));
    for (int i = 0; i < 50 && door_open; i++) tick();
    check("t6_left7", 32'({current_floor, door_open}), 32'({3'd7, 1'b0}));
    repeat (34) tick();
    check("t6_floor1", 32'({current_floor, moving, dir_up}), 32'({3'd1, 1'b1, 1'b0}));
    tick();
    check("t6_floor0", 32'({current_floor, moving}), 32'({3'd0, 1'b0}));
    tick();
    check("t6_door0", 32'({door_open, pending}), 32'({1'b1, 8'h00}));
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
